// File: rtl/pcc_pkg.sv
// Shared constants, FSM state type and helper functions for the pcc vector generator.
// The popcount helper is used by both the design and the bench scoreboard.
package pcc_pkg;

   localparam int POS_W  = 6;
   localparam int NEG_W  = 9;
   localparam int CNTP_W = 3;
   localparam int CNTN_W = 4;
   localparam int LEN_W  = 8;
   // Rotation counters only need to reach POS_W-1 / NEG_W-1.
   localparam int ROTP_W = 3;
   localparam int ROTN_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Limit a requested pos count to the number of bits in the pos vector.
   function automatic logic [CNTP_W-1:0] clamp_pos(input logic [CNTP_W-1:0] c);
      return (c > CNTP_W'(POS_W)) ? CNTP_W'(POS_W) : c;
   endfunction

   // Limit a requested neg count to the number of bits in the neg vector.
   function automatic logic [CNTN_W-1:0] clamp_neg(input logic [CNTN_W-1:0] c);
      return (c > CNTN_W'(NEG_W)) ? CNTN_W'(NEG_W) : c;
   endfunction

   // Number of ones in a vector of up to 16 bits (zero-extend narrower vectors).
   function automatic logic [4:0] popcount(input logic [15:0] v);
      logic [4:0] s;
      s = '0;
      for (int i = 0; i < 16; i++) begin
         s = s + {4'b0000, v[i]};
      end
      return s;
   endfunction

endpackage

// File: rtl/therm_rot.sv
// Combinational thermometer code of n ones, rotated left by r positions (r < W).
module therm_rot #(
   parameter int W  = 6,
   parameter int CW = 3,
   parameter int RW = 3
) (
   input  logic [CW-1:0] n,
   input  logic [RW-1:0] r,
   output logic [W-1:0]  v
);

   logic [W-1:0]   therm;
   logic [2*W-1:0] dbl;

   // Build therm(n), then rotate by shifting a doubled copy and taking the upper half.
   always_comb begin
      therm = '0;
      for (int i = 0; i < W; i++) begin
         therm[i] = (i < int'(n));
      end
      dbl = {therm, therm} << r;
      v   = dbl[2*W-1:W];
   end

endmodule

// File: rtl/pcc_vec_gen.sv
// Burst generator: turns (cnt_pos, cnt_neg, len) requests into len beats of rotating
// thermometer vectors holding exactly the clamped number of ones.
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready are both high.
// A producer holding valid high keeps its payload stable until the transfer; ready may be
// high or low independently of valid. req_* is accepted only in IDLE; out_* beats are held
// bit-stable while out_valid & !out_ready.
module pcc_vec_gen
   import pcc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [CNTP_W-1:0] req_cnt_pos,
   input  logic [CNTN_W-1:0] req_cnt_neg,
   input  logic [LEN_W-1:0]  req_len,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [POS_W-1:0]  out_pos,
   output logic [NEG_W-1:0]  out_neg,
   output logic              out_last,
   output logic              sat
);

   state_t              state_q, state_d;
   logic                rdy_q, rdy_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    beat_q, beat_d;
   logic [ROTP_W-1:0]   rp_q, rp_d;
   logic [ROTN_W-1:0]   rn_q, rn_d;
   logic [CNTP_W-1:0]   cp_q, cp_d;
   logic [CNTN_W-1:0]   cn_q, cn_d;
   logic                sat_q, sat_d;
   logic                ov_q, ov_d;
   logic [POS_W-1:0]    op_q, op_d;
   logic [NEG_W-1:0]    on_q, on_d;
   logic                ol_q, ol_d;

   logic                accept, hs;
   logic [CNTP_W-1:0]   cp_req, tr_pos_n;
   logic [CNTN_W-1:0]   cn_req, tr_neg_n;
   logic [ROTP_W-1:0]   rp_inc, tr_pos_r;
   logic [ROTN_W-1:0]   rn_inc, tr_neg_r;
   logic [POS_W-1:0]    tr_pos_v;
   logic [NEG_W-1:0]    tr_neg_v;

   // Handshake qualifiers, clamped request counts and wrapping rotation increments.
   always_comb begin
      accept   = req_valid & rdy_q;
      hs       = ov_q & out_ready;
      cp_req   = clamp_pos(req_cnt_pos);
      cn_req   = clamp_neg(req_cnt_neg);
      rp_inc   = (rp_q == ROTP_W'(POS_W - 1)) ? '0 : rp_q + ROTP_W'(1);
      rn_inc   = (rn_q == ROTN_W'(NEG_W - 1)) ? '0 : rn_q + ROTN_W'(1);
      // In IDLE the vector generators prepare beat 0 of a new request; in RUN, the next beat.
      tr_pos_n = (state_q == IDLE) ? cp_req : cp_q;
      tr_neg_n = (state_q == IDLE) ? cn_req : cn_q;
      tr_pos_r = (state_q == IDLE) ? '0 : rp_inc;
      tr_neg_r = (state_q == IDLE) ? '0 : rn_inc;
   end

   therm_rot #(.W(POS_W), .CW(CNTP_W), .RW(ROTP_W)) u_rot_pos (
      .n (tr_pos_n),
      .r (tr_pos_r),
      .v (tr_pos_v)
   );

   therm_rot #(.W(NEG_W), .CW(CNTN_W), .RW(ROTN_W)) u_rot_neg (
      .n (tr_neg_n),
      .r (tr_neg_r),
      .v (tr_neg_v)
   );

   // Next-state, counter and output-register logic; everything holds unless updated.
   always_comb begin
      state_d = state_q;
      rdy_d   = rdy_q;
      len_d   = len_q;
      beat_d  = beat_q;
      rp_d    = rp_q;
      rn_d    = rn_q;
      cp_d    = cp_q;
      cn_d    = cn_q;
      sat_d   = sat_q;
      ov_d    = ov_q;
      op_d    = op_q;
      on_d    = on_q;
      ol_d    = ol_q;
      case (state_q)
         IDLE: begin
            // Ready rises on the first cycle after reset and stays up while idle.
            rdy_d = 1'b1;
            if (accept && (req_len != '0)) begin
               state_d = RUN;
               rdy_d   = 1'b0;
               len_d   = req_len;
               cp_d    = cp_req;
               cn_d    = cn_req;
               sat_d   = (cp_req != req_cnt_pos) || (cn_req != req_cnt_neg);
               beat_d  = '0;
               rp_d    = '0;
               rn_d    = '0;
               ov_d    = 1'b1;
               op_d    = tr_pos_v;
               on_d    = tr_neg_v;
               ol_d    = (req_len == LEN_W'(1));
            end
         end
         RUN: begin
            if (hs) begin
               if (ol_q) begin
                  state_d = IDLE;
                  rdy_d   = 1'b1;
                  ov_d    = 1'b0;
                  op_d    = '0;
                  on_d    = '0;
                  ol_d    = 1'b0;
                  sat_d   = 1'b0;
                  beat_d  = '0;
                  rp_d    = '0;
                  rn_d    = '0;
               end else begin
                  beat_d = beat_q + LEN_W'(1);
                  rp_d   = rp_inc;
                  rn_d   = rn_inc;
                  op_d   = tr_pos_v;
                  on_d   = tr_neg_v;
                  // Next beat index is beat_q+1; it is last when it equals len-1.
                  ol_d   = (({1'b0, beat_q} + (LEN_W + 1)'(2)) == {1'b0, len_q});
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; async reset aborts any burst immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rdy_q   <= 1'b0;
         len_q   <= '0;
         beat_q  <= '0;
         rp_q    <= '0;
         rn_q    <= '0;
         cp_q    <= '0;
         cn_q    <= '0;
         sat_q   <= 1'b0;
         ov_q    <= 1'b0;
         op_q    <= '0;
         on_q    <= '0;
         ol_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rdy_q   <= rdy_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
         rp_q    <= rp_d;
         rn_q    <= rn_d;
         cp_q    <= cp_d;
         cn_q    <= cn_d;
         sat_q   <= sat_d;
         ov_q    <= ov_d;
         op_q    <= op_d;
         on_q    <= on_d;
         ol_q    <= ol_d;
      end
   end

   assign req_ready = rdy_q;
   assign out_valid = ov_q;
   assign out_pos   = op_q;
   assign out_neg   = on_q;
   assign out_last  = ol_q;
   assign sat       = sat_q;

endmodule

// File: tb/tb_pcc_vec_gen.sv
// Directed bench for pcc_vec_gen: table of bursts with hand-computed beats plus
// hand-written backpressure, zero-length and mid-burst reset sequences.
module tb_pcc_vec_gen;
   import pcc_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_cnt_pos;
   logic [3:0] req_cnt_neg;
   logic [7:0] req_len;
   logic       out_valid;
   logic       out_ready;
   logic [5:0] out_pos;
   logic [8:0] out_neg;
   logic       out_last;
   logic       sat;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [2:0]      cp;
      logic [3:0]      cn;
      logic [7:0]      len;
      logic            sat;
      logic [7:0][5:0] pos;
      logic [7:0][8:0] neg;
   } vec_t;

   vec_t vecs [8];

   always #5 clk = ~clk;

   pcc_vec_gen dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_cnt_pos (req_cnt_pos),
      .req_cnt_neg (req_cnt_neg),
      .req_len     (req_len),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pos     (out_pos),
      .out_neg     (out_neg),
      .out_last    (out_last),
      .sat         (sat)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Wait (bounded) for req_ready, then present one request for exactly one accepting edge.
   task automatic send_req(input logic [2:0] cp, input logic [3:0] cn, input logic [7:0] len);
      int n;
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("req_ready_before_req", {15'b0, req_ready}, 16'd1);
      req_valid   = 1'b1;
      req_cnt_pos = cp;
      req_cnt_neg = cn;
      req_len     = len;
      @(posedge clk);
      #1;
      req_valid   = 1'b0;
   endtask

   // Compare the presented beat against table values and the popcount invariant.
   task automatic check_beat(input string tag, input int k, input logic [5:0] ep,
                             input logic [8:0] en, input logic el, input logic es,
                             input logic [2:0] cpreq, input logic [3:0] cnreq);
      logic [4:0] cpm, cnm;
      cpm = (cpreq > 3'd6) ? 5'd6 : {2'b00, cpreq};
      cnm = (cnreq > 4'd9) ? 5'd9 : {1'b0, cnreq};
      chk($sformatf("%s_b%0d_valid", tag, k), {15'b0, out_valid}, 16'd1);
      chk($sformatf("%s_b%0d_pos", tag, k), {10'b0, out_pos}, {10'b0, ep});
      chk($sformatf("%s_b%0d_neg", tag, k), {7'b0, out_neg}, {7'b0, en});
      chk($sformatf("%s_b%0d_last", tag, k), {15'b0, out_last}, {15'b0, el});
      chk($sformatf("%s_b%0d_sat", tag, k), {15'b0, sat}, {15'b0, es});
      chk($sformatf("%s_b%0d_req_ready", tag, k), {15'b0, req_ready}, 16'd0);
      chk($sformatf("%s_b%0d_popc_pos", tag, k), {11'b0, popcount({10'b0, out_pos})},
          {11'b0, cpm});
      chk($sformatf("%s_b%0d_popc_neg", tag, k), {11'b0, popcount({7'b0, out_neg})},
          {11'b0, cnm});
   endtask

   // Drive one table burst with out_ready held high and check every beat plus the return to IDLE.
   task automatic run_vec(input vec_t v, input string tag);
      send_req(v.cp, v.cn, v.len);
      for (int k = 0; k < int'(v.len); k++) begin
         check_beat(tag, k, v.pos[k], v.neg[k], (k == int'(v.len) - 1), v.sat, v.cp, v.cn);
         if (k == 0) begin
            $display("  %s cmp log: pcnt=%0d ncnt=%0d pos>=neg=%0d", tag,
                     popcount({10'b0, out_pos}), popcount({7'b0, out_neg}),
                     popcount({10'b0, out_pos}) >= popcount({7'b0, out_neg}));
         end
         @(posedge clk);
         #1;
      end
      chk({tag, "_end_valid"}, {15'b0, out_valid}, 16'd0);
      chk({tag, "_end_ready"}, {15'b0, req_ready}, 16'd1);
   endtask

   initial begin
      rst         = 1'b1;
      req_valid   = 1'b0;
      req_cnt_pos = '0;
      req_cnt_neg = '0;
      req_len     = '0;
      out_ready   = 1'b1;

      for (int i = 0; i < 8; i++) vecs[i] = '0;
      // 1: basic rotation
      vecs[0].cp = 3'd2; vecs[0].cn = 4'd5; vecs[0].len = 8'd3; vecs[0].sat = 1'b0;
      vecs[0].pos[0] = 6'b000011; vecs[0].pos[1] = 6'b000110; vecs[0].pos[2] = 6'b001100;
      vecs[0].neg[0] = 9'b000011111; vecs[0].neg[1] = 9'b000111110;
      vecs[0].neg[2] = 9'b001111100;
      // 2: both counts clamped
      vecs[1].cp = 3'd7; vecs[1].cn = 4'd12; vecs[1].len = 8'd2; vecs[1].sat = 1'b1;
      vecs[1].pos[0] = 6'b111111; vecs[1].pos[1] = 6'b111111;
      vecs[1].neg[0] = 9'b111111111; vecs[1].neg[1] = 9'b111111111;
      // 3: single one walks and wraps after 6, neg count zero
      vecs[2].cp = 3'd1; vecs[2].cn = 4'd0; vecs[2].len = 8'd8; vecs[2].sat = 1'b0;
      vecs[2].pos[0] = 6'b000001; vecs[2].pos[1] = 6'b000010; vecs[2].pos[2] = 6'b000100;
      vecs[2].pos[3] = 6'b001000; vecs[2].pos[4] = 6'b010000; vecs[2].pos[5] = 6'b100000;
      vecs[2].pos[6] = 6'b000001; vecs[2].pos[7] = 6'b000010;
      // 3b: pos wrap with 3 ones, neg exactly full width (not clamped)
      vecs[3].cp = 3'd3; vecs[3].cn = 4'd9; vecs[3].len = 8'd7; vecs[3].sat = 1'b0;
      vecs[3].pos[0] = 6'b000111; vecs[3].pos[1] = 6'b001110; vecs[3].pos[2] = 6'b011100;
      vecs[3].pos[3] = 6'b111000; vecs[3].pos[4] = 6'b110001; vecs[3].pos[5] = 6'b100011;
      vecs[3].pos[6] = 6'b000111;
      for (int i = 0; i < 7; i++) vecs[3].neg[i] = 9'b111111111;
      // 3c: pos full width, neg one short of full
      vecs[4].cp = 3'd6; vecs[4].cn = 4'd8; vecs[4].len = 8'd3; vecs[4].sat = 1'b0;
      for (int i = 0; i < 3; i++) vecs[4].pos[i] = 6'b111111;
      vecs[4].neg[0] = 9'b011111111; vecs[4].neg[1] = 9'b111111110;
      vecs[4].neg[2] = 9'b111111101;
      // after mid-burst reset: restart at rotation 0
      vecs[5].cp = 3'd1; vecs[5].cn = 4'd2; vecs[5].len = 8'd2; vecs[5].sat = 1'b0;
      vecs[5].pos[0] = 6'b000001; vecs[5].pos[1] = 6'b000010;
      vecs[5].neg[0] = 9'b000000011; vecs[5].neg[1] = 9'b000000110;
      // request right after a zero-length one
      vecs[6].cp = 3'd1; vecs[6].cn = 4'd1; vecs[6].len = 8'd1; vecs[6].sat = 1'b0;
      vecs[6].pos[0] = 6'b000001; vecs[6].neg[0] = 9'b000000001;
      // backpressure burst
      vecs[7].cp = 3'd2; vecs[7].cn = 4'd3; vecs[7].len = 8'd4; vecs[7].sat = 1'b0;
      vecs[7].pos[0] = 6'b000011; vecs[7].pos[1] = 6'b000110; vecs[7].pos[2] = 6'b001100;
      vecs[7].pos[3] = 6'b011000;
      vecs[7].neg[0] = 9'b000000111; vecs[7].neg[1] = 9'b000001110;
      vecs[7].neg[2] = 9'b000011100; vecs[7].neg[3] = 9'b000111000;

      // Reset state
      #2;
      chk("rst_req_ready", {15'b0, req_ready}, 16'd0);
      chk("rst_out_valid", {15'b0, out_valid}, 16'd0);
      chk("rst_out_last", {15'b0, out_last}, 16'd0);
      chk("rst_sat", {15'b0, sat}, 16'd0);
      chk("rst_out_pos", {10'b0, out_pos}, 16'd0);
      chk("rst_out_neg", {7'b0, out_neg}, 16'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rel_req_ready_low", {15'b0, req_ready}, 16'd0);
      @(posedge clk);
      #1;
      chk("rel_req_ready_high", {15'b0, req_ready}, 16'd1);

      // Table-driven bursts
      for (int i = 0; i < 5; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Backpressure on beat index 1 for 3 cycles
      send_req(vecs[7].cp, vecs[7].cn, vecs[7].len);
      check_beat("bp", 0, vecs[7].pos[0], vecs[7].neg[0], 1'b0, 1'b0, 3'd2, 4'd3);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         check_beat($sformatf("bp_hold%0d", c), 1, vecs[7].pos[1], vecs[7].neg[1], 1'b0,
                    1'b0, 3'd2, 4'd3);
         if (c < 3) begin
            @(posedge clk);
            #1;
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check_beat("bp", 2, vecs[7].pos[2], vecs[7].neg[2], 1'b0, 1'b0, 3'd2, 4'd3);
      @(posedge clk);
      #1;
      check_beat("bp", 3, vecs[7].pos[3], vecs[7].neg[3], 1'b1, 1'b0, 3'd2, 4'd3);
      @(posedge clk);
      #1;
      chk("bp_end_valid", {15'b0, out_valid}, 16'd0);
      chk("bp_end_ready", {15'b0, req_ready}, 16'd1);

      // Zero-length request, then an immediate follow-up
      send_req(3'd3, 4'd3, 8'd0);
      chk("len0_no_valid", {15'b0, out_valid}, 16'd0);
      chk("len0_ready", {15'b0, req_ready}, 16'd1);
      run_vec(vecs[6], "after_len0");

      // Reset mid-burst, asserted away from a clock edge
      send_req(3'd1, 4'd2, 8'd10);
      check_beat("mr", 0, 6'b000001, 9'b000000011, 1'b0, 1'b0, 3'd1, 4'd2);
      @(posedge clk);
      #1;
      check_beat("mr", 1, 6'b000010, 9'b000000110, 1'b0, 1'b0, 3'd1, 4'd2);
      @(posedge clk);
      #1;
      check_beat("mr", 2, 6'b000100, 9'b000001100, 1'b0, 1'b0, 3'd1, 4'd2);
      #3;
      rst = 1'b1;
      #1;
      chk("mr_valid", {15'b0, out_valid}, 16'd0);
      chk("mr_pos", {10'b0, out_pos}, 16'd0);
      chk("mr_neg", {7'b0, out_neg}, 16'd0);
      chk("mr_last", {15'b0, out_last}, 16'd0);
      chk("mr_sat", {15'b0, sat}, 16'd0);
      chk("mr_ready", {15'b0, req_ready}, 16'd0);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("mr_ready_after", {15'b0, req_ready}, 16'd1);
      chk("mr_valid_after", {15'b0, out_valid}, 16'd0);
      run_vec(vecs[5], "after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
